// File: rtl/logic_unit_arbiter_pkg.sv
// Shared constants and types for the two-requester logic-unit arbiter.
package logic_unit_arbiter_pkg;

    localparam int DATA_W = 32;

    localparam logic [2:0] LOP_AND = 3'd0;
    localparam logic [2:0] LOP_OR  = 3'd1;
    localparam logic [2:0] LOP_NOR = 3'd2;
    localparam logic [2:0] LOP_INV = 3'd3;
    localparam logic [2:0] LOP_BUF = 3'd4;

    // EMPTY/FULL mirrors whether the result register holds an unconsumed result.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/logic_unit_arbiter_logic32_unit.sv
// 32-bit gate arrays plus the opcode mux that forms the shared logic unit.
module and32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    assign y = a & b;
endmodule

module or32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    assign y = a | b;
endmodule

module nor32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    assign y = ~(a | b);
endmodule

module inv32 (
    input  logic [31:0] a,
    output logic [31:0] y
);
    assign y = ~a;
endmodule

module buf32 (
    input  logic [31:0] a,
    output logic [31:0] y
);
    assign y = a;
endmodule

module logic32_unit
    import logic_unit_arbiter_pkg::*;
(
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] res,
    output logic              err
);
    logic [DATA_W-1:0] and_y, or_y, nor_y, inv_y, buf_y;

    and32 u_and (.a(a), .b(b), .y(and_y));
    or32  u_or  (.a(a), .b(b), .y(or_y));
    nor32 u_nor (.a(a), .b(b), .y(nor_y));
    inv32 u_inv (.a(a), .y(inv_y));
    buf32 u_buf (.a(a), .y(buf_y));

    // Reserved opcodes yield zero with the error flag raised.
    always_comb begin
        res = '0;
        err = 1'b0;
        case (op)
            LOP_AND: res = and_y;
            LOP_OR:  res = or_y;
            LOP_NOR: res = nor_y;
            LOP_INV: res = inv_y;
            LOP_BUF: res = buf_y;
            default: err = 1'b1;
        endcase
    end
endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one logic32_unit between two requesters, with a registered result stage.
module logic_unit_arbiter
    import logic_unit_arbiter_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ0,
    input  logic [2:0]        OP0,
    input  logic [DATA_W-1:0] A0,
    input  logic [DATA_W-1:0] B0,
    output logic              GNT0,
    input  logic              REQ1,
    input  logic [2:0]        OP1,
    input  logic [DATA_W-1:0] A1,
    input  logic [DATA_W-1:0] B1,
    output logic              GNT1,
    output logic              RES_VALID,
    input  logic              RES_READY,
    output logic [DATA_W-1:0] RES,
    output logic              RES_ID,
    output logic              RES_ERR,
    output logic [CNT_W-1:0]  GCNT0,
    output logic [CNT_W-1:0]  GCNT1
);
    state_t            state, state_nx;
    logic              pri;
    logic              can_acc;
    logic              any_gnt;
    logic [2:0]        mux_op;
    logic [DATA_W-1:0] mux_a, mux_b;
    logic [DATA_W-1:0] lu_res;
    logic              lu_err;

    assign can_acc   = (state == ST_EMPTY) || RES_READY;
    assign RES_VALID = (state == ST_FULL);

    // The pointer only breaks ties; a lone requester is always served.
    always_comb begin
        GNT0 = 1'b0;
        GNT1 = 1'b0;
        if (!RST && can_acc) begin
            if (REQ0 && REQ1) begin
                GNT0 = ~pri;
                GNT1 = pri;
            end else begin
                GNT0 = REQ0;
                GNT1 = REQ1;
            end
        end
    end

    assign any_gnt = GNT0 | GNT1;
    assign mux_op  = GNT1 ? OP1 : OP0;
    assign mux_a   = GNT1 ? A1  : A0;
    assign mux_b   = GNT1 ? B1  : B0;

    logic32_unit u_lu (
        .op  (mux_op),
        .a   (mux_a),
        .b   (mux_b),
        .res (lu_res),
        .err (lu_err)
    );

    always_comb begin
        state_nx = state;
        case (state)
            ST_EMPTY: if (any_gnt) state_nx = ST_FULL;
            ST_FULL:  if (RES_READY && !any_gnt) state_nx = ST_EMPTY;
            default:  state_nx = ST_EMPTY;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= ST_EMPTY;
            pri     <= 1'b0;
            RES     <= '0;
            RES_ID  <= 1'b0;
            RES_ERR <= 1'b0;
            GCNT0   <= '0;
            GCNT1   <= '0;
        end else begin
            state <= state_nx;
            if (any_gnt) begin
                RES     <= lu_res;
                RES_ID  <= GNT1;
                RES_ERR <= lu_err;
                pri     <= ~GNT1;
            end
            if (GNT0 && (GCNT0 != {CNT_W{1'b1}})) GCNT0 <= GCNT0 + 1'b1;
            if (GNT1 && (GCNT1 != {CNT_W{1'b1}})) GCNT1 <= GCNT1 + 1'b1;
        end
    end
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Scoreboard bench for logic_unit_arbiter: directed scenarios, random traffic and counter saturation.
module tb_logic_unit_arbiter;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, req1;
    logic [2:0]    op0, op1;
    logic [W-1:0]  a0, b0, a1, b1;
    logic          gnt0, gnt1;
    logic          res_valid, res_ready;
    logic [W-1:0]  res;
    logic          res_id, res_err;
    logic [15:0]   gcnt0, gcnt1;

    always #5 clk = ~clk;

    logic_unit_arbiter dut (
        .CLK(clk), .RST(rst),
        .REQ0(req0), .OP0(op0), .A0(a0), .B0(b0), .GNT0(gnt0),
        .REQ1(req1), .OP1(op1), .A1(a1), .B1(b1), .GNT1(gnt1),
        .RES_VALID(res_valid), .RES_READY(res_ready),
        .RES(res), .RES_ID(res_id), .RES_ERR(res_err),
        .GCNT0(gcnt0), .GCNT1(gcnt1)
    );

    // Scoreboard entries are {err, id, result}.
    logic [W+1:0] exp_q[$];
    int checks = 0;
    int passed = 0;
    int pri_m, cnt0_m, cnt1_m;
    logic eg0, eg1, g0_s, g1_s;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [W:0] ref_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            3'd0: return {1'b0, a & b};
            3'd1: return {1'b0, a | b};
            3'd2: return {1'b0, ~(a | b)};
            3'd3: return {1'b0, ~a};
            3'd4: return {1'b0, a};
            default: return {1'b1, {W{1'b0}}};
        endcase
    endfunction

    function automatic logic [15:0] sat16(input int c);
        return (c > 65535) ? 16'hFFFF : 16'(c);
    endfunction

    // One clock: check grants and counters against the model, then advance the model.
    task automatic step();
        logic can;
        logic [W:0] r;
        @(negedge clk);
        #1;
        can = (exp_q.size() == 0) || res_ready;
        eg0 = 1'b0;
        eg1 = 1'b0;
        if (!rst && can) begin
            if (req0 && req1) begin
                eg0 = (pri_m == 0);
                eg1 = (pri_m != 0);
            end else begin
                eg0 = req0;
                eg1 = req1;
            end
        end
        check("gnt0", 64'(gnt0), 64'(eg0));
        check("gnt1", 64'(gnt1), 64'(eg1));
        check("gcnt0", 64'(gcnt0), 64'(sat16(cnt0_m)));
        check("gcnt1", 64'(gcnt1), 64'(sat16(cnt1_m)));
        g0_s = gnt0;
        g1_s = gnt1;
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            pri_m  = 0;
            cnt0_m = 0;
            cnt1_m = 0;
        end else if (eg0 || eg1) begin
            r = eg0 ? ref_op(op0, a0, b0) : ref_op(op1, a1, b1);
            exp_q.push_back({r[W], eg1, r[W-1:0]});
            pri_m = eg0 ? 1 : 0;
            if (eg0) cnt0_m++;
            else     cnt1_m++;
        end
        #1;
    endtask

    // Monitor: compares the presented result while it is valid, pops it when consumed.
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if (exp_q.size() > 0) begin
                check("res_valid", 64'(res_valid), 64'(1));
                check("res", 64'({res_err, res_id, res}), 64'(exp_q[0]));
                if (res_ready) void'(exp_q.pop_front());
            end else begin
                check("res_valid_idle", 64'(res_valid), 64'(0));
            end
        end
    end

    task automatic new_req0();
        req0 = ($urandom_range(0, 3) != 0);
        op0  = 3'($urandom_range(0, 7));
        a0   = $urandom;
        b0   = $urandom;
    endtask

    task automatic new_req1();
        req1 = ($urandom_range(0, 3) != 0);
        op1  = 3'($urandom_range(0, 7));
        a1   = $urandom;
        b1   = $urandom;
    endtask

    initial begin
        rst = 1'b1; res_ready = 1'b1;
        req0 = 1'b0; op0 = '0; a0 = '0; b0 = '0;
        req1 = 1'b0; op1 = '0; a1 = '0; b1 = '0;
        pri_m = 0; cnt0_m = 0; cnt1_m = 0;
        step();
        step();
        rst = 1'b0;
        check("reset_valid", 64'(res_valid), 64'(0));
        check("reset_res", 64'({res_err, res_id, res}), 64'(0));
        check("reset_gcnt", 64'({gcnt0, gcnt1}), 64'(0));

        // Single request with the consumer ready.
        req0 = 1'b1; op0 = 3'd0; a0 = 32'hF0F0_1234; b0 = 32'hFF00_FF00;
        step();
        check("single_gnt0", 64'(g0_s), 64'(1));
        req0 = 1'b0;
        check("single_res", 64'(res), 64'(32'hF000_1200));
        check("single_id", 64'(res_id), 64'(0));
        check("single_valid", 64'(res_valid), 64'(1));
        check("single_gcnt0", 64'(gcnt0), 64'(1));

        // Reset arriving right after a grant.
        req0 = 1'b1;
        step();
        rst = 1'b1;
        step();
        check("rst_gnt0", 64'(g0_s), 64'(0));
        check("rst_valid", 64'(res_valid), 64'(0));
        check("rst_gcnt0", 64'(gcnt0), 64'(0));
        rst = 1'b0; req0 = 1'b0;

        // Contention: alternates starting from requester 0.
        req0 = 1'b1; req1 = 1'b1; op1 = 3'd1; a1 = 32'h1234_0000; b1 = 32'h0000_5678;
        for (int k = 0; k < 4; k++) begin
            step();
            check("cont_gnt1", 64'(g1_s), 64'(k % 2));
            check("cont_gnt0", 64'(g0_s), 64'((k + 1) % 2));
        end
        check("cont_gcnt0", 64'(gcnt0), 64'(2));
        check("cont_gcnt1", 64'(gcnt1), 64'(2));
        req0 = 1'b0; req1 = 1'b0;
        step();

        // Backpressure on a NOR result.
        req1 = 1'b1; op1 = 3'd2; a1 = '0; b1 = '0; res_ready = 1'b0;
        step();
        check("bp_first_gnt1", 64'(g1_s), 64'(1));
        for (int k = 0; k < 3; k++) begin
            step();
            check("bp_stall_gnt1", 64'(g1_s), 64'(0));
            check("bp_hold_res", 64'(res), 64'(32'hFFFF_FFFF));
            check("bp_hold_id", 64'(res_id), 64'(1));
        end
        res_ready = 1'b1;
        step();
        check("bp_regrant", 64'(g1_s), 64'(1));
        check("bp_valid", 64'(res_valid), 64'(1));
        req1 = 1'b0;
        step();

        // Reserved opcode, then INV.
        req0 = 1'b1; op0 = 3'd6; a0 = $urandom; b0 = $urandom;
        step();
        check("rsv_res", 64'(res), 64'(0));
        check("rsv_err", 64'(res_err), 64'(1));
        op0 = 3'd3; a0 = 32'h0000_00FF;
        step();
        check("inv_res", 64'(res), 64'(32'hFFFF_FF00));
        check("inv_err", 64'(res_err), 64'(0));
        req0 = 1'b0;
        step();

        // Random traffic; requesters hold their operation until granted.
        new_req0();
        new_req1();
        for (int n = 0; n < 3000; n++) begin
            res_ready = ($urandom_range(0, 2) != 0);
            rst = ($urandom_range(0, 199) == 0);
            step();
            if (eg0 || !req0) new_req0();
            if (eg1 || !req1) new_req1();
        end
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0; res_ready = 1'b1;
        step();

        // Saturation of the requester-0 grant counter.
        rst = 1'b1;
        step();
        rst = 1'b0;
        req0 = 1'b1; op0 = 3'd4; a0 = 32'hA5A5_5A5A;
        for (int n = 0; n < 65537; n++) step();
        check("sat_gcnt0", 64'(gcnt0), 64'(16'hFFFF));
        step();
        check("sat_nowrap", 64'(gcnt0), 64'(16'hFFFF));
        req0 = 1'b0;
        step();
        step();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
